// File: rtl/lcd_hd44780_receiver.sv
// Receive-side model of the HD44780 4-bit LCD bus: syncs the pins, assembles bytes, tracks the DDRAM cursor.
// Optional timing checks are built when LCD_RX_TIMING_CHECK_EN is defined.
module lcd_hd44780_receiver #(
  parameter int BUSY_CYCLES       = 40,
  parameter int CLEAR_BUSY_CYCLES = 1640,
  parameter int MIN_EN_HIGH       = 23
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic       iLCD_StrataFlashControl,
  input  logic [3:0] iLCD_Data,
  output logic [7:0] oByte,
  output logic       oByteValid,
  output logic       oIsData,
  output logic       oCharWrite,
  output logic [7:0] oChar,
  output logic [6:0] oCharAddr,
  output logic [6:0] oCursor,
  output logic       oDisplayOn,
  output logic       oFourBitMode,
  output logic       oProtocolError,
  output logic       oTimingError
);

  typedef enum logic [1:0] {INIT8, NIB_HI, NIB_LO} state_t;

  logic [7:0] pin_s1, pin_s2;
  logic       en_d;
  logic [5:0] cap;                 // {rs, rw, data} held from the last Enable-high sample
  state_t     state, nxt;
  logic [3:0] hi_nib;
  logic       hi_rs;
  logic       inc;
  logic       fire, nrs, perr;
  logic [7:0] nb;

  wire en_s   = pin_s2[7];
  wire sf_s   = pin_s2[4];
  wire strobe = en_d & ~en_s & sf_s;
  wire cap_rs = cap[5];
  wire cap_rw = cap[4];
  wire [3:0] cap_d = cap[3:0];

  function automatic logic [6:0] step(input logic [6:0] c, input logic up);
    if (up) begin
      if (c == 7'h27)      step = 7'h40;
      else if (c == 7'h67) step = 7'h00;
      else                 step = c + 7'd1;
    end else begin
      if (c == 7'h40)      step = 7'h27;
      else if (c == 7'h00) step = 7'h67;
      else                 step = c - 7'd1;
    end
  endfunction

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pin_s1 <= '0;
      pin_s2 <= '0;
      en_d   <= 1'b0;
      cap    <= '0;
    end else begin
      pin_s1 <= {iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite,
                 iLCD_StrataFlashControl, iLCD_Data};
      pin_s2 <= pin_s1;
      en_d   <= en_s;
      if (en_s) cap <= {pin_s2[6], pin_s2[5], pin_s2[3:0]};
    end
  end

  always_comb begin
    fire = 1'b0;
    nb   = 8'h00;
    nrs  = 1'b0;
    perr = 1'b0;
    nxt  = state;
    if (strobe) begin
      if (cap_rw) perr = 1'b1;
      else begin
        case (state)
          INIT8: begin
            if (!cap_rs && (cap_d == 4'h3 || cap_d == 4'h2)) begin
              fire = 1'b1;
              nb   = {cap_d, 4'h0};
              if (cap_d == 4'h2) nxt = NIB_HI;
            end else perr = 1'b1;
          end
          NIB_HI: nxt = NIB_LO;
          NIB_LO: begin
            nxt = NIB_HI;
            if (cap_rs != hi_rs) perr = 1'b1;
            else begin
              fire = 1'b1;
              nb   = {hi_nib, cap_d};
              nrs  = cap_rs;
            end
          end
          default: nxt = INIT8;
        endcase
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state          <= INIT8;
      hi_nib         <= '0;
      hi_rs          <= 1'b0;
      inc            <= 1'b1;
      oByte          <= '0;
      oByteValid     <= 1'b0;
      oIsData        <= 1'b0;
      oCharWrite     <= 1'b0;
      oChar          <= '0;
      oCharAddr      <= '0;
      oCursor        <= '0;
      oDisplayOn     <= 1'b0;
      oFourBitMode   <= 1'b0;
      oProtocolError <= 1'b0;
    end else begin
      oByteValid <= 1'b0;
      oCharWrite <= 1'b0;
      state      <= nxt;
      if (strobe && !cap_rw && state == NIB_HI) begin
        hi_nib <= cap_d;
        hi_rs  <= cap_rs;
      end
      if (perr) oProtocolError <= 1'b1;
      if (fire && state == INIT8 && nb[7:4] == 4'h2) oFourBitMode <= 1'b1;
      if (fire) begin
        oByte      <= nb;
        oIsData    <= nrs;
        oByteValid <= 1'b1;
        if (nrs) begin
          oCharWrite <= 1'b1;
          oChar      <= nb;
          oCharAddr  <= oCursor;
          oCursor    <= step(oCursor, inc);
        end else begin
          casez (nb)
            8'b1???????: oCursor <= nb[6:0];
            8'b01??????, 8'b001?????, 8'b0001????: ;
            8'b00001???: oDisplayOn <= nb[2];
            8'b000001??: inc <= nb[1];
            8'b0000001?: oCursor <= '0;
            8'b00000001: begin oCursor <= '0; inc <= 1'b1; end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef LCD_RX_TIMING_CHECK_EN
  logic [15:0] busy, width;
  wire long_cmd = !nrs && (nb == 8'h01 || nb[7:1] == 7'h01);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      busy         <= '0;
      width        <= '0;
      oTimingError <= 1'b0;
    end else begin
      if (fire)            busy <= long_cmd ? 16'(CLEAR_BUSY_CYCLES) : 16'(BUSY_CYCLES);
      else if (busy != 0)  busy <= busy - 16'd1;
      // width holds the synced high time until the cycle the fall is seen
      if (en_s) begin
        if (width != 16'hFFFF) width <= width + 16'd1;
      end else width <= '0;
      if (strobe && (width < 16'(MIN_EN_HIGH) || busy != 0)) oTimingError <= 1'b1;
    end
  end
`else
  logic [2:0] unused_cfg;
  assign unused_cfg   = {BUSY_CYCLES[0], CLEAR_BUSY_CYCLES[0], MIN_EN_HIGH[0]};
  assign oTimingError = 1'b0;
`endif

endmodule
